// File: rtl/bnn_pkg.sv
// Shared constants and FSM state type for the binary fully-connected classifier.
package bnn_pkg;

  localparam int N_CLASS = 10;
  localparam int VEC_W   = 256;
  localparam int RES_W   = 10;
  localparam int CLS_W   = 4;

  // Index of the last class / weight row, at address width.
  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_CLASS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bnn_argmax_acc.sv
// Running arg-max over the class scores of one classification.
// The first accepted score always loads; later ones replace it only when
// strictly greater, so equal scores keep the lowest class index.
module bnn_argmax_acc
  import bnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [CLS_W-1:0] index_i,
  input  logic [RES_W-1:0] score_i,
  output logic [CLS_W-1:0] best_idx_o,
  output logic [RES_W-1:0] best_score_o
);

  logic             have_q;
  logic [CLS_W-1:0] idx_q;
  logic [RES_W-1:0] score_q;
  logic             take_d;

  assign take_d = valid_i && (!have_q || (score_i > score_q));

  // Hold the best (index, score) seen since the last clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_q  <= 1'b0;
      idx_q   <= '0;
      score_q <= '0;
    end else if (clear_i) begin
      have_q  <= 1'b0;
      idx_q   <= '0;
      score_q <= '0;
    end else if (take_d) begin
      have_q  <= 1'b1;
      idx_q   <= index_i;
      score_q <= score_i;
    end
  end

  assign best_idx_o   = idx_q;
  assign best_score_o = score_q;

endmodule

// File: rtl/bnn_fc_sequencer.sv
// Sequencer for the binary FC popcount core: latches a feature vector on
// start, reads the weight ROM row by row, streams {feature, weight} beats to
// the core and reduces the returned scores to an arg-max classification.
module bnn_fc_sequencer
  import bnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [VEC_W-1:0] i_feature,
  output logic             o_busy,
  output logic             o_wrom_en,
  output logic [CLS_W-1:0] o_wrom_addr,
  input  logic [VEC_W-1:0] i_wrom_data,
  output logic             o_fc_valid,
  output logic [VEC_W-1:0] o_fc_data,
  output logic [VEC_W-1:0] o_fc_weight,
  input  logic             i_fc_valid,
  input  logic [RES_W-1:0] i_fc_result,
  output logic             o_done,
  output logic [CLS_W-1:0] o_class,
  output logic [RES_W-1:0] o_score
);

  state_e           state_q;
  logic [VEC_W-1:0] feature_q;
  logic [VEC_W-1:0] weight_q;
  logic [CLS_W-1:0] addr_q;
  logic [CLS_W-1:0] res_cnt_q;
  logic             wrom_en_q;
  logic             rom_vld_q;
  logic             fc_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             start_acc_d;
  logic             res_take_d;
  logic             last_res_d;

  // A start only counts in IDLE; results only count once a run is underway.
  assign start_acc_d = (state_q == IDLE) && i_start;
  assign res_take_d  = (state_q != IDLE) && i_fc_valid;
  assign last_res_d  = res_take_d && (res_cnt_q == LAST_IDX);

  // Control FSM: issues the ROM reads, counts results and flags completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      feature_q <= '0;
      addr_q    <= '0;
      res_cnt_q <= '0;
      wrom_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q   <= ISSUE;
            feature_q <= i_feature;
            addr_q    <= '0;
            res_cnt_q <= '0;
            wrom_en_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ISSUE: begin
          if (addr_q == LAST_IDX) begin
            wrom_en_q <= 1'b0;
            addr_q    <= '0;
            state_q   <= DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
          if (last_res_d) begin
            wrom_en_q <= 1'b0;
            addr_q    <= '0;
            state_q   <= DONE;
            done_q    <= 1'b1;
          end
        end
        DRAIN: begin
          if (last_res_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      if (res_take_d) begin
        res_cnt_q <= res_cnt_q + 1'b1;
      end
    end
  end

  // Beat pipeline: ROM data lands one cycle after the read, the beat one after that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_vld_q  <= 1'b0;
      fc_valid_q <= 1'b0;
      weight_q   <= '0;
    end else begin
      rom_vld_q  <= wrom_en_q;
      fc_valid_q <= rom_vld_q;
      if (rom_vld_q) begin
        weight_q <= i_wrom_data;
      end
    end
  end

  bnn_argmax_acc u_argmax (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_acc_d),
    .valid_i      (res_take_d),
    .index_i      (res_cnt_q),
    .score_i      (i_fc_result),
    .best_idx_o   (o_class),
    .best_score_o (o_score)
  );

  assign o_busy      = busy_q;
  assign o_wrom_en   = wrom_en_q;
  assign o_wrom_addr = addr_q;
  assign o_fc_valid  = fc_valid_q;
  assign o_fc_data   = feature_q;
  assign o_fc_weight = weight_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_bnn_fc_sequencer.sv
// Testbench for bnn_fc_sequencer: ROM and 4-cycle FC core models, a
// queue-based scoreboard, and a monitor comparing beats and classifications.
module tb_bnn_fc_sequencer;
  import bnn_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [VEC_W-1:0] i_feature = '0;
  logic             o_busy;
  logic             o_wrom_en;
  logic [CLS_W-1:0] o_wrom_addr;
  logic [VEC_W-1:0] i_wrom_data;
  logic             o_fc_valid;
  logic [VEC_W-1:0] o_fc_data;
  logic [VEC_W-1:0] o_fc_weight;
  logic             i_fc_valid;
  logic [RES_W-1:0] i_fc_result;
  logic             o_done;
  logic [CLS_W-1:0] o_class;
  logic [RES_W-1:0] o_score;

  bnn_fc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_feature   (i_feature),
    .o_busy      (o_busy),
    .o_wrom_en   (o_wrom_en),
    .o_wrom_addr (o_wrom_addr),
    .i_wrom_data (i_wrom_data),
    .o_fc_valid  (o_fc_valid),
    .o_fc_data   (o_fc_data),
    .o_fc_weight (o_fc_weight),
    .i_fc_valid  (i_fc_valid),
    .i_fc_result (i_fc_result),
    .o_done      (o_done),
    .o_class     (o_class),
    .o_score     (o_score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int doneCount = 0;
  int lastStart = 0;

  logic [VEC_W-1:0] rom [N_CLASS];

  // Weight ROM: row appears one cycle after the read enable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) i_wrom_data <= '0;
    else if (o_wrom_en && int'(o_wrom_addr) < N_CLASS) i_wrom_data <= rom[int'(o_wrom_addr)];
  end

  // FC core: matching-bit count of each beat, returned 4 cycles later.
  logic             pipeV [4];
  logic [RES_W-1:0] pipeS [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pipeV[i] <= 1'b0;
        pipeS[i] <= '0;
      end
    end else begin
      pipeV[0] <= o_fc_valid;
      pipeS[0] <= RES_W'($countones(~(o_fc_data ^ o_fc_weight)));
      for (int i = 1; i < 4; i++) begin
        pipeV[i] <= pipeV[i-1];
        pipeS[i] <= pipeS[i-1];
      end
    end
  end
  assign i_fc_valid  = pipeV[3];
  assign i_fc_result = pipeS[3];

  typedef struct {
    int               cyc;
    logic [VEC_W-1:0] data;
    logic [VEC_W-1:0] weight;
  } beat_t;

  typedef struct {
    int cyc;
    int cls;
    int score;
  } res_t;

  beat_t beatQ[$];
  res_t  resQ[$];
  beat_t mb;
  res_t  mr;

  task automatic checkOutput(input string name, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] randVec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Issue one start at the current negedge and record what the run must produce.
  task automatic applyStimulus(input logic [VEC_W-1:0] f);
    int best;
    int bestS;
    int s;
    i_start   = 1'b1;
    i_feature = f;
    lastStart = cyc;
    best  = 0;
    bestS = -1;
    for (int k = 0; k < N_CLASS; k++) begin
      beatQ.push_back('{cyc + 3 + k, f, rom[k]});
      s = $countones(~(f ^ rom[k]));
      if (s > bestS) begin
        bestS = s;
        best  = k;
      end
    end
    resQ.push_back('{cyc + 17, best, bestS});
    @(negedge clk);
    i_start   = 1'b0;
    i_feature = randVec();
  endtask

  task automatic pulseIgnoredStart();
    i_start   = 1'b1;
    i_feature = randVec();
    @(negedge clk);
    i_start   = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((resQ.size() != 0 || beatQ.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (resQ.size() != 0 || beatQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL run_timeout: %0d beats and %0d results still pending, expected 0", beatQ.size(), resQ.size());
      beatQ.delete();
      resQ.delete();
    end
    @(negedge clk);
    checkOutput("busy_after_run", VEC_W'(o_busy), '0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat or a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_fc_valid) begin
        if (beatQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL beat_unexpected: o_fc_valid=1 at cycle %0d, expected 0", cyc);
        end else begin
          mb = beatQ.pop_front();
          checkOutput("beat_cycle", VEC_W'(cyc), VEC_W'(mb.cyc));
          checkOutput("fc_data", o_fc_data, mb.data);
          checkOutput("fc_weight", o_fc_weight, mb.weight);
        end
      end
      if (o_done) begin
        doneCount++;
        if (resQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL done_unexpected: o_done=1 at cycle %0d, expected 0", cyc);
        end else begin
          mr = resQ.pop_front();
          checkOutput("done_cycle", VEC_W'(cyc), VEC_W'(mr.cyc));
          checkOutput("class", VEC_W'(o_class), VEC_W'(mr.cls));
          checkOutput("score", VEC_W'(o_score), VEC_W'(mr.score));
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, VEC_W'(o_busy), '0);
    checkOutput({tag, "_wrom_en"}, VEC_W'(o_wrom_en), '0);
    checkOutput({tag, "_wrom_addr"}, VEC_W'(o_wrom_addr), '0);
    checkOutput({tag, "_fc_valid"}, VEC_W'(o_fc_valid), '0);
    checkOutput({tag, "_fc_data"}, o_fc_data, '0);
    checkOutput({tag, "_fc_weight"}, o_fc_weight, '0);
    checkOutput({tag, "_done"}, VEC_W'(o_done), '0);
    checkOutput({tag, "_class"}, VEC_W'(o_class), '0);
    checkOutput({tag, "_score"}, VEC_W'(o_score), '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [VEC_W-1:0] f;
    logic [VEC_W-1:0] ones;
    int s;
    int savedDone;
    ones = '1;

    for (int k = 0; k < N_CLASS; k++) rom[k] = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single all-ones row wins with the maximum score.
    $display("[TB] directed: row 3 all-ones");
    for (int k = 0; k < N_CLASS; k++) rom[k] = (k == 3) ? ones : '0;
    applyStimulus(ones);
    checkOutput("busy_running", VEC_W'(o_busy), VEC_W'(1));
    waitIdle(40);

    // Full tie: lowest index must win.
    $display("[TB] directed: all rows equal feature");
    f = randVec();
    for (int k = 0; k < N_CLASS; k++) rom[k] = f;
    applyStimulus(f);
    waitIdle(40);

    // Row k matches 20k+5 bits: strictly increasing, last row wins with 185.
    $display("[TB] directed: graded match counts");
    f = randVec();
    for (int k = 0; k < N_CLASS; k++) rom[k] = f ^ (ones << (20 * k + 5));
    applyStimulus(f);
    waitIdle(40);

    // Starts during a run are ignored; the first legal restart is cycle 18.
    $display("[TB] directed: ignored starts and back-to-back restart");
    f = randVec();
    for (int k = 0; k < N_CLASS; k++) rom[k] = randVec();
    applyStimulus(f);
    s = lastStart;
    while (cyc < s + 5) @(negedge clk);
    pulseIgnoredStart();
    while (cyc < s + 17) @(negedge clk);
    pulseIgnoredStart();
    checkOutput("restart_cycle", VEC_W'(cyc), VEC_W'(s + 18));
    applyStimulus(randVec());
    waitIdle(60);

    // Reset mid-run: outputs clear at once and no completion follows.
    $display("[TB] directed: abort and recovery");
    f = randVec();
    for (int k = 0; k < N_CLASS; k++) rom[k] = randVec();
    applyStimulus(f);
    s = lastStart;
    while (cyc < s + 8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    beatQ.delete();
    resQ.delete();
    savedDone = doneCount;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("no_done_after_abort", VEC_W'(doneCount), VEC_W'(savedDone));
    for (int k = 0; k < N_CLASS; k++) rom[k] = (k == 6) ? f : randVec();
    applyStimulus(f);
    waitIdle(40);

    // Random runs, with occasional duplicated rows to exercise ties.
    $display("[TB] random runs");
    for (int t = 0; t < 8; t++) begin
      f = randVec();
      for (int k = 0; k < N_CLASS; k++) begin
        if (k > 0 && $urandom_range(3) == 0) rom[k] = rom[$urandom_range(k - 1)];
        else if ($urandom_range(4) == 0) rom[k] = f ^ (ones << $urandom_range(255));
        else rom[k] = randVec();
      end
      applyStimulus(f);
      waitIdle(40);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
